isp_wb_ctrl: RTL and testbench
==============================

ISP_WB_CTRL -- requirements
Module: isp_wb_ctrl

Interface
REQ-001 Parameter NSLV, default 4: number of downstream ISP slaves (camera cfg, MIPI, UART/I2C, PWM/DAC); legal 1..4.
REQ-002 Parameter TMO, default 255: slave-ack timeout in cycles; legal 2..1023.
REQ-003 Parameter ERR_DATA, default 32'hDEAD_BEEF: read data returned on error.
REQ-004 wb_clk_i  in  1  sole clock; all logic on rising edge.
REQ-005 wb_rst_i  in  1  reset, asynchronous, active-high.
REQ-006 wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  management Wishbone master controls.
REQ-007 wbs_sel_i  in  4; wbs_adr_i  in  32; wbs_dat_i  in  32  master byte-select/address/write data.
REQ-008 wbs_ack_o  out  1; wbs_dat_o  out  32  response to master.
REQ-009 s_cyc_o, s_stb_o  out  NSLV each  one-hot per-slave cycle/strobe.
REQ-010 s_we_o  out  1; s_sel_o  out  4; s_adr_o  out  12; s_dat_o  out  32  shared registered request bus.
REQ-011 s_ack_i  in  NSLV; s_dat_i  in  NSLV*32 (slave k at bits 32k+31:32k)  slave responses.
REQ-012 err_irq_o  out  1  one-cycle pulse on any error; err_cnt_o  out  8  saturating error count.

Function
REQ-013 Decode: slave index = wbs_adr_i[13:12]; offset = wbs_adr_i[11:0]; request is unmapped if wbs_adr_i[15:14]!=0 or index>=NSLV.
REQ-014 FSM states IDLE, BUSY, RESP; reset state IDLE.
REQ-015 IDLE: on wbs_cyc_i&wbs_stb_i, register we/sel/offset/dat/index; mapped -> BUSY, unmapped -> RESP with error flag.
REQ-016 BUSY: s_cyc_o[idx]=s_stb_o[idx]=1, all other bits 0; timeout counter increments each cycle from 0.
REQ-017 BUSY -> RESP when s_ack_i[idx]=1; latch s_dat_i slice idx; acks from non-selected slaves are ignored.
REQ-018 BUSY -> RESP with error flag when counter reaches TMO-1 without ack; if ack and timeout coincide, ack wins, no error.
REQ-019 RESP: s_cyc_o/s_stb_o all 0; wbs_ack_o=1 for exactly one cycle; wbs_dat_o = latched data (reads) or ERR_DATA (error); next state IDLE.
REQ-020 wbs_dat_o = 0 whenever wbs_ack_o=0; for writes wbs_dat_o=0 unless error.
REQ-021 Latency: slave ack in cycle N -> wbs_ack_o in cycle N+1; unmapped request accepted cycle N -> ack cycle N+1.
REQ-022 Abort: wbs_cyc_i falling while BUSY -> IDLE next cycle, slave strobes drop, no wbs_ack_o, no error.
REQ-023 A new request is not accepted in RESP; earliest next accept is the IDLE cycle after RESP.
REQ-024 Error (unmapped or timeout): err_irq_o pulses in the RESP cycle; err_cnt_o increments, saturates at 255.

Reset
REQ-025 Asserting wb_rst_i at any time, including mid-transaction, forces within the same cycle: state IDLE, all s_cyc_o/s_stb_o=0, wbs_ack_o=0, wbs_dat_o=0, err_irq_o=0, err_cnt_o=0, counter=0, latched request fields=0.
REQ-026 After deassertion, no ack is issued for a transaction interrupted by reset.

Structure
REQ-027 Shared package isp_wb_pkg holds FSM state enum, slave index widths, address field positions, ERR_DATA default.
REQ-028 One sub-module isp_wb_tmo (loadable timeout counter with clear/expire) is natural; rest is flat.

Verification
REQ-029 Read adr 0x0000_1004, slave 1 acks 3 cycles after strobe with 0x1234_5678 -> s_adr_o=0x004, wbs_ack_o one cycle later, wbs_dat_o=0x1234_5678, err_cnt_o=0.
REQ-030 Write adr 0x0000_3010, dat 0xA5A5_0001, sel 0x3, slave 3 acks -> s_we_o=1, s_dat_o=0xA5A5_0001, s_sel_o=0x3, single ack.
REQ-031 Read adr 0x0000_2000, slave 2 never acks, TMO=8 -> ack after 8 BUSY cycles, wbs_dat_o=0xDEAD_BEEF, err_irq_o pulse, err_cnt_o=1.
REQ-032 Read adr 0x0000_4000 -> ack next cycle, no s_stb_o activity, wbs_dat_o=0xDEAD_BEEF, err_cnt_o increments.
REQ-033 Slave 0 acks while slave 1 selected, then wbs_cyc_i dropped -> no wbs_ack_o, strobes clear, FSM IDLE.
REQ-034 Reset asserted while BUSY on slave 2 -> all outputs 0 immediately; 260 forced errors -> err_cnt_o=255.

Source files
------------

// File: rtl/isp_wb_pkg.sv
// Shared types and address-field layout for the ISP Wishbone slave controller.
package isp_wb_pkg;

  typedef enum logic [1:0] {StIdle, StBusy, StResp} wb_state_e;

  localparam int unsigned IdxW   = 2;
  localparam int unsigned IdxLsb = 12;
  localparam int unsigned OffW   = 12;
  localparam int unsigned HiLsb  = 14;
  localparam int unsigned HiMsb  = 15;
  localparam int unsigned TmoW   = 10;

  localparam logic [31:0] ErrDataDef = 32'hDEAD_BEEF;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/isp_wb_tmo.sv
// Slave-ack timeout counter: cleared outside BUSY, counts up while enabled.
module isp_wb_tmo
  import isp_wb_pkg::*;
#(
  parameter int unsigned TMO = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  logic [TmoW-1:0] cnt_q;

  assign expire = en && (cnt_q == TmoW'(TMO - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && !expire) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/isp_wb_ctrl.sv
// Management Wishbone to per-slave ISP bus bridge with decode, timeout and error reporting.
module isp_wb_ctrl
  import isp_wb_pkg::*;
#(
  parameter int unsigned NSLV     = 4,
  parameter int unsigned TMO      = 255,
  parameter logic [31:0] ERR_DATA = ErrDataDef
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 wbs_cyc_i,
  input  logic                 wbs_stb_i,
  input  logic                 wbs_we_i,
  input  logic [3:0]           wbs_sel_i,
  input  logic [31:0]          wbs_adr_i,
  input  logic [31:0]          wbs_dat_i,
  output logic                 wbs_ack_o,
  output logic [31:0]          wbs_dat_o,
  output logic [NSLV-1:0]      s_cyc_o,
  output logic [NSLV-1:0]      s_stb_o,
  output logic                 s_we_o,
  output logic [3:0]           s_sel_o,
  output logic [OffW-1:0]      s_adr_o,
  output logic [31:0]          s_dat_o,
  input  logic [NSLV-1:0]      s_ack_i,
  input  logic [NSLV*32-1:0]   s_dat_i,
  output logic                 err_irq_o,
  output logic [7:0]           err_cnt_o
);

  wb_state_e       state_q;
  logic [NSLV-1:0] s_cyc_q;
  logic            we_q;
  logic [3:0]      sel_q;
  logic [OffW-1:0] off_q;
  logic [31:0]     wdat_q;
  logic [IdxW-1:0] idx_q;
  logic            ack_q;
  logic [31:0]     rdat_q;
  logic            err_irq_q;
  logic [7:0]      err_cnt_q;

  logic [IdxW-1:0] req_idx;
  logic            mapped;
  logic            hit;
  logic            expire;
  logic [31:0]     slv_rdata;
  logic            unused_adr_hi;

  assign req_idx       = wbs_adr_i[IdxLsb +: IdxW];
  assign mapped        = (wbs_adr_i[HiMsb:HiLsb] == '0) && (32'(req_idx) < 32'(NSLV));
  // Strobe vector is one-hot, so masking with it ignores acks from other slaves.
  assign hit           = |(s_ack_i & s_cyc_q);
  assign unused_adr_hi = ^wbs_adr_i[31:HiMsb+1];

  always_comb begin
    slv_rdata = '0;
    for (int k = 0; k < int'(NSLV); k++) begin
      if (idx_q == IdxW'(k)) slv_rdata = s_dat_i[32*k +: 32];
    end
  end

  isp_wb_tmo #(
    .TMO (TMO)
  ) u_tmo (
    .clk    (wb_clk_i),
    .rst    (wb_rst_i),
    .clr    (state_q != StBusy),
    .en     (state_q == StBusy),
    .expire (expire)
  );

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q   <= StIdle;
      s_cyc_q   <= '0;
      we_q      <= 1'b0;
      sel_q     <= '0;
      off_q     <= '0;
      wdat_q    <= '0;
      idx_q     <= '0;
      ack_q     <= 1'b0;
      rdat_q    <= '0;
      err_irq_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      err_irq_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (wbs_cyc_i && wbs_stb_i) begin
            we_q   <= wbs_we_i;
            sel_q  <= wbs_sel_i;
            off_q  <= wbs_adr_i[OffW-1:0];
            wdat_q <= wbs_dat_i;
            idx_q  <= req_idx;
            if (mapped) begin
              state_q <= StBusy;
              s_cyc_q <= NSLV'(1) << req_idx;
            end else begin
              state_q   <= StResp;
              ack_q     <= 1'b1;
              rdat_q    <= ERR_DATA;
              err_irq_q <= 1'b1;
              err_cnt_q <= sat_inc8(err_cnt_q);
            end
          end
        end
        StBusy: begin
          // Abort beats a same-cycle ack: the master has already walked away.
          if (!wbs_cyc_i) begin
            state_q <= StIdle;
            s_cyc_q <= '0;
          end else if (hit) begin
            state_q <= StResp;
            s_cyc_q <= '0;
            ack_q   <= 1'b1;
            rdat_q  <= we_q ? 32'h0 : slv_rdata;
          end else if (expire) begin
            state_q   <= StResp;
            s_cyc_q   <= '0;
            ack_q     <= 1'b1;
            rdat_q    <= ERR_DATA;
            err_irq_q <= 1'b1;
            err_cnt_q <= sat_inc8(err_cnt_q);
          end
        end
        StResp: begin
          state_q <= StIdle;
          ack_q   <= 1'b0;
          rdat_q  <= '0;
        end
        default: begin
          state_q <= StIdle;
          s_cyc_q <= '0;
          ack_q   <= 1'b0;
          rdat_q  <= '0;
        end
      endcase
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = rdat_q;
  assign s_cyc_o   = s_cyc_q;
  assign s_stb_o   = s_cyc_q;
  assign s_we_o    = we_q;
  assign s_sel_o   = sel_q;
  assign s_adr_o   = off_q;
  assign s_dat_o   = wdat_q;
  assign err_irq_o = err_irq_q;
  assign err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_isp_wb_ctrl.sv
// Directed bench for isp_wb_ctrl: decode, acks, timeout, abort, reset and error saturation.
module tb_isp_wb_ctrl;

  localparam int unsigned NSLV = 4;
  localparam int unsigned TMO  = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         cyc, stb, we;
  logic [3:0]   sel;
  logic [31:0]  adr, wdat;
  logic         ack;
  logic [31:0]  rdat;
  logic [3:0]   s_cyc, s_stb;
  logic         s_we;
  logic [3:0]   s_sel;
  logic [11:0]  s_adr;
  logic [31:0]  s_dat;
  logic [3:0]   s_ack;
  logic [127:0] s_rdat;
  logic         irq;
  logic [7:0]   ecnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  isp_wb_ctrl #(
    .NSLV     (NSLV),
    .TMO      (TMO),
    .ERR_DATA (32'hDEAD_BEEF)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wbs_cyc_i (cyc),
    .wbs_stb_i (stb),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_adr_i (adr),
    .wbs_dat_i (wdat),
    .wbs_ack_o (ack),
    .wbs_dat_o (rdat),
    .s_cyc_o   (s_cyc),
    .s_stb_o   (s_stb),
    .s_we_o    (s_we),
    .s_sel_o   (s_sel),
    .s_adr_o   (s_adr),
    .s_dat_o   (s_dat),
    .s_ack_i   (s_ack),
    .s_dat_i   (s_rdat),
    .err_irq_o (irq),
    .err_cnt_o (ecnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
  endtask

  task automatic idle_bus();
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cyc = 0; stb = 0; we = 0; sel = 0; adr = 0; wdat = 0;
    s_ack = 0; s_rdat = '0;
    #1;
    chk("rst_ack", {31'b0, ack}, 0);
    chk("rst_stb", {28'b0, s_stb}, 0);
    chk("rst_dat", rdat, 0);
    chk("rst_ecnt", {24'b0, ecnt}, 0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Read slave 1, ack three cycles after strobe.
    req(1'b0, 32'h0000_1004, 32'h0, 4'hF);
    tick();
    idle_bus(); cyc = 1'b1;
    chk("rd_stb", {28'b0, s_stb}, 32'h2);
    chk("rd_cyc", {28'b0, s_cyc}, 32'h2);
    chk("rd_adr", {20'b0, s_adr}, 32'h004);
    tick(); tick();
    chk("rd_noack", {31'b0, ack}, 0);
    s_ack = 4'b0010; s_rdat[63:32] = 32'h1234_5678;
    tick();
    s_ack = 0; cyc = 1'b0;
    chk("rd_ack", {31'b0, ack}, 1);
    chk("rd_dat", rdat, 32'h1234_5678);
    chk("rd_stb_clr", {28'b0, s_stb}, 0);
    chk("rd_ecnt", {24'b0, ecnt}, 0);
    tick();
    chk("rd_ack_1cyc", {31'b0, ack}, 0);
    chk("rd_dat_zero", rdat, 0);

    // Write slave 3, immediate ack.
    req(1'b1, 32'h0000_3010, 32'hA5A5_0001, 4'h3);
    tick();
    chk("wr_we", {31'b0, s_we}, 1);
    chk("wr_dat", s_dat, 32'hA5A5_0001);
    chk("wr_sel", {28'b0, s_sel}, 32'h3);
    chk("wr_stb", {28'b0, s_stb}, 32'h8);
    s_ack = 4'b1000; s_rdat[127:96] = 32'hFFFF_FFFF;
    tick();
    s_ack = 0;
    chk("wr_ack", {31'b0, ack}, 1);
    chk("wr_dat_o", rdat, 0);
    idle_bus();
    tick();
    chk("wr_single_ack", {31'b0, ack}, 0);

    // Timeout on slave 2.
    req(1'b0, 32'h0000_2000, 32'h0, 4'hF);
    tick();
    for (int i = 0; i < 8; i++) begin
      chk("tmo_busy_ack", {31'b0, ack}, 0);
      chk("tmo_busy_stb", {28'b0, s_stb}, 32'h4);
      tick();
    end
    chk("tmo_ack", {31'b0, ack}, 1);
    chk("tmo_dat", rdat, 32'hDEAD_BEEF);
    chk("tmo_irq", {31'b0, irq}, 1);
    chk("tmo_ecnt", {24'b0, ecnt}, 1);
    idle_bus();
    tick();
    chk("tmo_irq_pulse", {31'b0, irq}, 0);

    // Unmapped address: ack next cycle, no slave activity.
    req(1'b0, 32'h0000_4000, 32'h0, 4'hF);
    tick();
    idle_bus();
    chk("unm_ack", {31'b0, ack}, 1);
    chk("unm_stb", {28'b0, s_stb}, 0);
    chk("unm_dat", rdat, 32'hDEAD_BEEF);
    chk("unm_irq", {31'b0, irq}, 1);
    chk("unm_ecnt", {24'b0, ecnt}, 2);
    tick();

    // Ack and timeout in the same cycle: ack wins.
    req(1'b0, 32'h0000_2008, 32'h0, 4'hF);
    tick();
    repeat (7) tick();
    s_ack = 4'b0100; s_rdat[95:64] = 32'h0BAD_F00D;
    tick();
    s_ack = 0; idle_bus();
    chk("race_ack", {31'b0, ack}, 1);
    chk("race_dat", rdat, 32'h0BAD_F00D);
    chk("race_irq", {31'b0, irq}, 0);
    chk("race_ecnt", {24'b0, ecnt}, 2);
    tick();

    // Wrong-slave ack then abort.
    req(1'b0, 32'h0000_1000, 32'h0, 4'hF);
    tick();
    stb = 1'b0;
    s_ack = 4'b0001; s_rdat[31:0] = 32'h5555_AAAA;
    tick();
    chk("abrt_wrong_ack", {31'b0, ack}, 0);
    chk("abrt_busy_stb", {28'b0, s_stb}, 32'h2);
    cyc = 1'b0;
    tick();
    s_ack = 0;
    chk("abrt_stb", {28'b0, s_stb}, 0);
    chk("abrt_ack", {31'b0, ack}, 0);
    tick();
    chk("abrt_no_late_ack", {31'b0, ack}, 0);
    chk("abrt_ecnt", {24'b0, ecnt}, 2);

    // Reset mid-transaction on slave 2.
    req(1'b0, 32'h0000_2000, 32'h0, 4'hF);
    tick();
    chk("rb_stb", {28'b0, s_stb}, 32'h4);
    rst = 1'b1;
    #1;
    chk("rb_stb0", {28'b0, s_stb}, 0);
    chk("rb_ack0", {31'b0, ack}, 0);
    chk("rb_ecnt0", {24'b0, ecnt}, 0);
    chk("rb_adr0", {20'b0, s_adr}, 0);
    idle_bus();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("rb_no_ack", {31'b0, ack}, 0);
    end

    // 260 unmapped requests saturate the error counter.
    for (int i = 1; i <= 260; i++) begin
      req(1'b0, 32'h0000_4000, 32'h0, 4'hF);
      tick();
      idle_bus();
      if (i == 255) chk("sat_255", {24'b0, ecnt}, 255);
      tick();
    end
    chk("sat_final", {24'b0, ecnt}, 255);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
